// File: rtl/dense_pkg.sv
// dense_pkg: shared fixed-point defaults and helpers for the NN layer blocks.
// Provides acc_width() and sat_shift(). No ports (package only).
package dense_pkg;

    localparam int DENSE_WIDTH = 16;
    localparam int DENSE_FRAC  = 8;

    // Common carrier width for sat_shift so layers of any size can share it.
    localparam int SAT_W = 64;

    // Width of an accumulator holding N full-width products without overflow.
    function automatic int acc_width(input int width, input int n);
        return 2 * width + $clog2(n) + 1;
    endfunction

    // Arithmetic shift (floor) by frac, then clamp to a signed width-bit range.
    // The result is returned sign-extended to SAT_W bits.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac,
        input int                      width
    );
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (sh > hi) begin
            return hi;
        end
        if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/dense_layer_if.sv
// dense_layer_if: operand/result bus of the dense layer.
// Signals: in_valid, weights[M][N], inputs[B][N] -> out_valid, result[B][M].
interface dense_layer_if #(
    parameter int B     = 2,
    parameter int M     = 3,
    parameter int N     = 4,
    parameter int WIDTH = 16
);

    logic                    in_valid;
    logic signed [WIDTH-1:0] weights [M][N];
    logic signed [WIDTH-1:0] inputs  [B][N];
    logic                    out_valid;
    logic signed [WIDTH-1:0] result  [B][M];

    modport master (
        output in_valid,
        output weights,
        output inputs,
        input  out_valid,
        input  result
    );

    modport slave (
        input  in_valid,
        input  weights,
        input  inputs,
        output out_valid,
        output result
    );

endinterface

// File: rtl/dense_neuron.sv
// dense_neuron: one N-term signed dot product, two register stages.
// Ports: clk, rst, load_i (stage-1 enable), en_i (stage-2 enable), w_i, x_i, y_o.
// Macro DENSE_RELU_EN clamps negative results to zero.
module dense_neuron
    import dense_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] w_i [N],
    input  logic signed [WIDTH-1:0] x_i [N],
    output logic signed [WIDTH-1:0] y_o
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = acc_width(WIDTH, N);

    logic signed [PW-1:0]    prod_q [N];
    logic signed [AW-1:0]    acc_d;
    logic signed [SAT_W-1:0] sat_d;
    logic signed [WIDTH-1:0] y_d;
    logic signed [WIDTH-1:0] y_q;

    always_comb begin
        acc_d = '0;
        for (int n = 0; n < N; n++) begin
            acc_d = acc_d + AW'(prod_q[n]);
        end
        sat_d = sat_shift(SAT_W'(acc_d), FRAC, WIDTH);
        y_d   = WIDTH'(sat_d);
`ifdef DENSE_RELU_EN
        if (sat_d[SAT_W-1]) begin
            y_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N; n++) begin
                prod_q[n] <= '0;
            end
            y_q <= '0;
        end else begin
            if (load_i) begin
                for (int n = 0; n < N; n++) begin
                    prod_q[n] <= PW'(w_i[n]) * PW'(x_i[n]);
                end
            end
            if (en_i) begin
                y_q <= y_d;
            end
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/dense_layer.sv
// dense_layer: B x M fixed-point fully-connected layer, 2-cycle latency.
// Ports: clk, rst (async, active high), bus (dense_layer_if.slave).
// Macro DENSE_RELU_EN selects ReLU output; default is linear.
module dense_layer
    import dense_pkg::*;
#(
    parameter int B     = 2,
    parameter int M     = 3,
    parameter int N     = 4,
    parameter int WIDTH = DENSE_WIDTH,
    parameter int FRAC  = DENSE_FRAC
) (
    input  logic         clk,
    input  logic         rst,
    dense_layer_if.slave bus
);

    logic v1_d;
    logic v1_q;
    logic ov_d;
    logic ov_q;

    assign v1_d = bus.in_valid;
    assign ov_d = v1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            ov_q <= ov_d;
        end
    end

    assign bus.out_valid = ov_q;

    for (genvar b = 0; b < B; b++) begin : g_b
        for (genvar m = 0; m < M; m++) begin : g_m
            logic signed [WIDTH-1:0] y;

            dense_neuron #(
                .N     (N),
                .WIDTH (WIDTH),
                .FRAC  (FRAC)
            ) u_neuron (
                .clk    (clk),
                .rst    (rst),
                .load_i (bus.in_valid),
                .en_i   (v1_q),
                .w_i    (bus.weights[m]),
                .x_i    (bus.inputs[b]),
                .y_o    (y)
            );

            assign bus.result[b][m] = y;
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// tb_dense_layer: scoreboard bench for dense_layer.
// Builds with or without DENSE_RELU_EN.
module tb_dense_layer;

    localparam int B = 2;
    localparam int M = 3;
    localparam int N = 4;
    localparam int W = 16;
    localparam int F = 8;
    localparam int RW = B * M * W;

    typedef struct packed {
        logic [RW-1:0] r;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dense_layer_if #(.B(B), .M(M), .N(N), .WIDTH(W)) bus ();

    dense_layer #(.B(B), .M(M), .N(N), .WIDTH(W), .FRAC(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [W-1:0] wt  [M][N];
    logic signed [W-1:0] xin [B][N];
    exp_t                sb [$];
    logic [RW-1:0]       last;

    function automatic int relu(input int v);
`ifdef DENSE_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [RW-1:0] pk(input int ev [B][M]);
        logic [RW-1:0] r;
        r = '0;
        for (int b = 0; b < B; b++)
            for (int m = 0; m < M; m++)
                r[(b*M+m)*W +: W] = W'(relu(ev[b][m]));
        return r;
    endfunction

    function automatic logic [RW-1:0] model();
        int ev [B][M];
        for (int b = 0; b < B; b++) begin
            for (int m = 0; m < M; m++) begin
                longint s;
                s = 0;
                for (int n = 0; n < N; n++)
                    s += longint'(wt[m][n]) * longint'(xin[b][n]);
                s = s >>> F;
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                ev[b][m] = int'(s);
            end
        end
        return pk(ev);
    endfunction

    function automatic logic [RW-1:0] cur();
        logic [RW-1:0] r;
        for (int b = 0; b < B; b++)
            for (int m = 0; m < M; m++)
                r[(b*M+m)*W +: W] = bus.result[b][m];
        return r;
    endfunction

    task automatic issue(input bit uc, input logic [RW-1:0] ce);
        exp_t e;
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                bus.weights[m][n] = wt[m][n];
        for (int b = 0; b < B; b++)
            for (int n = 0; n < N; n++)
                bus.inputs[b][n] = xin[b][n];
        bus.in_valid = 1'b1;
        e.r   = uc ? ce : model();
        e.cyc = cyc + 2;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int k);
        bus.in_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic fill(input int wv, input int xv);
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                wt[m][n] = W'(wv);
        for (int b = 0; b < B; b++)
            for (int n = 0; n < N; n++)
                xin[b][n] = W'(xv);
    endtask

    task automatic rnd();
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                wt[m][n] = W'($urandom);
        for (int b = 0; b < B; b++)
            for (int n = 0; n < N; n++)
                xin[b][n] = W'($urandom);
    endtask

    initial begin
        int ev [B][M];
        bus.in_valid = 1'b0;
        fill(0, 0);
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                bus.weights[m][n] = '0;
        for (int b = 0; b < B; b++)
            for (int n = 0; n < N; n++)
                bus.inputs[b][n] = '0;
        last = '0;

        #12;
        ntests++;
        if (bus.out_valid !== 1'b0 || cur() !== '0) begin
            nfail++;
            $display("FAIL reset_state: out_valid=%b result=%h want 0", bus.out_valid, cur());
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (bus.out_valid) begin
                        if (sb.size() == 0) begin
                            ntests++;
                            nfail++;
                            $display("FAIL spurious_out_valid: out_valid=1 at cyc %0d want 0", cyc);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            ntests++;
                            if (e.cyc != cyc) begin
                                nfail++;
                                $display("FAIL latency: got cyc %0d want cyc %0d", cyc, e.cyc);
                            end
                            ntests++;
                            if (cur() !== e.r) begin
                                nfail++;
                                $display("FAIL result: got %h want %h", cur(), e.r);
                            end
                        end
                        last = cur();
                    end else begin
                        ntests++;
                        if (cur() !== last) begin
                            nfail++;
                            $display("FAIL hold: got %h want %h", cur(), last);
                        end
                    end
                end
            end
        join_none

        wt  = '{'{9, -4, -30, -10}, '{16, 9, -5, 41}, '{10, 4, 24, -35}};
        xin = '{'{256, 512, 768, 1024}, '{512, -256, 0, 768}};
        ev  = '{'{-129, 183, -50}, '{-8, 146, -89}};
        issue(1'b1, pk(ev));
        idle(3);

        fill(32767, 32767);
        ev = '{'{32767, 32767, 32767}, '{32767, 32767, 32767}};
        issue(1'b1, pk(ev));
        fill(-32768, 32767);
        ev = '{'{-32768, -32768, -32768}, '{-32768, -32768, -32768}};
        issue(1'b1, pk(ev));
        idle(2);

        fill(0, 0);
        wt[0][0]  = 1;
        xin[0][0] = 1;
        ev = '{'{0, 0, 0}, '{0, 0, 0}};
        issue(1'b1, pk(ev));
        wt[0][0] = -1;
        ev = '{'{-1, 0, 0}, '{0, 0, 0}};
        issue(1'b1, pk(ev));
        idle(3);

        for (int i = 0; i < 3; i++) begin
            rnd();
            issue(1'b0, '0);
        end
        idle(3);

        for (int i = 0; i < 12; i++) begin
            rnd();
            issue(1'b0, '0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        wt  = '{'{9, -4, -30, -10}, '{16, 9, -5, 41}, '{10, 4, 24, -35}};
        xin = '{'{256, 512, 768, 1024}, '{512, -256, 0, 768}};
        issue(1'b0, '0);
        idle(3);
        rnd();
        issue(1'b0, '0);
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        ntests++;
        if (bus.out_valid !== 1'b0 || cur() !== '0) begin
            nfail++;
            $display("FAIL async_reset: out_valid=%b result=%h want 0", bus.out_valid, cur());
        end
        sb.delete();
        last = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(5);

        ntests++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d outstanding want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dense_layer.md
Name: dense_layer

Overview:
- Pipelined, fully parallel fixed-point fully-connected layer: result[b][m] = sat(Σn weights[m][n]·inputs[b][n] >> FRAC) for all B batch rows and M neurons.
- Inputs and outputs are signed two's-complement Q(WIDTH-FRAC).FRAC; the default is Q8.8.
- The block sits between activation producers and the next layer in the NN accelerator datapath.
- Fixed two-cycle latency, accepts a new operand set every cycle, no backpressure.

Parameters:
- B, 2: batch rows processed per transaction.
- M, 3: output neurons (weight rows).
- N, 4: input features (dot-product length).
- WIDTH, 16: bit width of every weight, input and result element.
- FRAC, 8: fractional bits of the fixed-point format.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies weights/inputs this cycle.
- weights  in  signed [WIDTH-1:0] unpacked [M][N]  weight matrix, row m = neuron m.
- inputs  in  signed [WIDTH-1:0] unpacked [B][N]  input vectors, row b = batch b.
- out_valid  out  1  result holds a new transaction.
- result  out  signed [WIDTH-1:0] unpacked [B][M]  layer outputs.

Behaviour:
- Reset: while rst=1, all pipeline registers, result[*][*] and out_valid are forced to 0 immediately, independent of clk. Reset mid-operation discards in-flight transactions; no out_valid pulse for them after release.
- Stage 1, on clk when in_valid=1:
  - Register all B·M·N products weights[m][n]*inputs[b][n], full 2·WIDTH signed.
  - Set v1=1. When in_valid=0, v1=0 and product registers hold.
- Stage 2, on clk when v1=1:
  - Sum the N products per (b,m) in an accumulator of 2·WIDTH+$clog2(N)+1 bits.
  - Arithmetic right shift by FRAC (floor toward −inf, no rounding).
  - Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Write to result[b][m].
  - out_valid=v1, a one-cycle pulse per transaction.
- Latency: in_valid at edge k gives result/out_valid at edge k+2. Back-to-back in_valid produces back-to-back out_valid.
- result holds its last value when out_valid=0.
- All arithmetic is signed. No overflow is possible before the saturation stage.

Optional Feature:
- DENSE_RELU_EN defined: after saturation, a negative value is replaced by 0 before the result register, so result[b][m] = max(0, sat(...)).
- DENSE_RELU_EN undefined: a linear output, exactly as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package dense_pkg:
  - default WIDTH/FRAC localparams;
  - function acc_width(WIDTH,N);
  - function sat_shift(acc, FRAC, WIDTH) doing shift-plus-saturation, shared with other layers.
- Sub-module dense_neuron: one N-element dot product with both pipeline stages, output in WIDTH bits. dense_layer instantiates B×M of these via generate and owns the valid pipeline.

Test Plan:
- Nominal case, stimulus (Q8.8 raw):
  - weights = {{9,−4,−30,−10},{16,9,−5,41},{10,4,24,−35}};
  - inputs = {{256,512,768,1024},{512,−256,0,768}};
  - required result[0] = {−129,183,−50} and result[1] = {−8,146,−89}, with out_valid exactly 2 cycles after in_valid.
- Saturation: all weights and inputs = 32767 → every result = 32767. Weights = −32768, inputs = 32767 → every result = −32768.
- Floor shift: weights[0][0]=1, inputs[0][0]=1, others 0 → result[0][0]=0. Same with weight −1 → result[0][0]=−1.
- Throughput: three consecutive in_valid cycles with distinct operand sets → three consecutive out_valid pulses, results in order. in_valid=0 gap → out_valid=0 and result unchanged.
- Reset: assert rst asynchronously one cycle after in_valid → result=0 and out_valid=0 immediately, and no out_valid after release.
- DENSE_RELU_EN build, nominal stimulus → result[0] = {0,183,0}, result[1] = {0,146,0}.
